// File: rtl/sim_tick_pkg.sv
// Shared encodings for the HIL simulation time-base controller.
package sim_tick_pkg;

   typedef enum logic [1:0] {
      OP_STOP   = 2'b00,
      OP_RUN    = 2'b01,
      OP_STEP   = 2'b10,
      OP_SETDIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_e;

   localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/sim_prescaler.sv
// Tick prescaler: counts 0..div-1 while enabled, flags `due` on the last count and
// applies a staged divisor at the next wrap so a running period is never cut short.
module sim_prescaler #(
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned DIV_RESET = 250
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic             stage,
   input  logic [DIV_W-1:0] div_in,
   output logic             due
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] stage_q;
   logic             stage_vld_q;

   assign due = en && (cnt_q >= div_q - DIV_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         div_q       <= DIV_W'(DIV_RESET);
         stage_q     <= '0;
         stage_vld_q <= 1'b0;
      end else begin
         if (!en || due) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + DIV_W'(1);
         end
         // A staged value left over from a stopped run is applied once idle.
         if (load) begin
            div_q       <= div_in;
            stage_vld_q <= 1'b0;
         end else if ((due || !en) && stage_vld_q) begin
            div_q       <= stage_q;
            stage_vld_q <= 1'b0;
         end
         if (stage) begin
            stage_q     <= div_in;
            stage_vld_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sim_tick_ctrl.sv
// Run/stop/single-step controller for the HIL simulation time base: issues sim_tick
// strobes at a programmable rate, withholds them while the plant is busy, flags overruns.
module sim_tick_ctrl
   import sim_tick_pkg::*;
#(
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned DIV_RESET = 250,
   parameter int unsigned DIV_MIN   = sim_tick_pkg::DIV_MIN,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk_50Mhz,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [DIV_W-1:0] cmd_arg,
   output logic             cmd_err,
   input  logic             model_busy,
   input  logic             overrun_clr,
   output logic             sim_tick,
   output logic             sim_clk,
   output logic             step_done,
   output logic             overrun,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] tick_count
);

   state_e           state_q;
   logic [DIV_W-1:0] remain_q;
   logic             pending_q;
   logic             done_arm_q;
   op_e              op;
   logic             accept, active, stop_acc, ticking, issue, due;
   logic             div_load, div_stage;
   logic [DIV_W-1:0] div_arg;

   assign op        = op_e'(cmd_op);
   assign cmd_ready = 1'b1;
   assign accept    = cmd_valid;
   assign active    = (state_q != ST_IDLE);
   assign stop_acc  = accept && (op == OP_STOP);
   assign ticking   = active && !stop_acc;
   assign issue     = ticking && !model_busy && (pending_q || due);
   assign div_arg   = (cmd_arg < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cmd_arg;
   assign div_load  = accept && (op == OP_SETDIV) && !active;
   assign div_stage = accept && (op == OP_SETDIV) && active;
   assign state     = state_q;

   sim_prescaler #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
   ) u_prescaler (
      .clk    (clk_50Mhz),
      .rst_n  (rst_n),
      .en     (active),
      .load   (div_load),
      .stage  (div_stage),
      .div_in (div_arg),
      .due    (due)
   );

   always_ff @(posedge clk_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         remain_q   <= '0;
         pending_q  <= 1'b0;
         done_arm_q <= 1'b0;
         sim_tick   <= 1'b0;
         sim_clk    <= 1'b0;
         step_done  <= 1'b0;
         cmd_err    <= 1'b0;
         overrun    <= 1'b0;
         tick_count <= '0;
      end else begin
         sim_tick   <= 1'b0;
         cmd_err    <= 1'b0;
         step_done  <= done_arm_q;
         done_arm_q <= 1'b0;

         // A deadline passing while a tick is still owed drops that tick.
         if (ticking && due && pending_q) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
         if (ticking) begin
            pending_q <= model_busy && (pending_q || due);
         end
         if (issue) begin
            sim_tick   <= 1'b1;
            sim_clk    <= ~sim_clk;
            tick_count <= tick_count + CNT_W'(1);
         end

         case (state_q)
            ST_IDLE: begin
               if (accept && (op == OP_RUN)) begin
                  state_q <= ST_RUN;
               end else if (accept && (op == OP_STEP)) begin
                  if (cmd_arg == '0) begin
                     step_done <= 1'b1;
                  end else begin
                     state_q  <= ST_STEP;
                     remain_q <= cmd_arg;
                  end
               end
            end
            ST_RUN, ST_STEP: begin
               if (stop_acc) begin
                  state_q   <= ST_IDLE;
                  pending_q <= 1'b0;
               end else begin
                  if (accept && ((op == OP_RUN) || (op == OP_STEP))) begin
                     cmd_err <= 1'b1;
                  end
                  if ((state_q == ST_STEP) && issue) begin
                     if (remain_q == DIV_W'(1)) begin
                        state_q    <= ST_IDLE;
                        done_arm_q <= 1'b1;
                     end else begin
                        remain_q <= remain_q - DIV_W'(1);
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sim_tick_ctrl.sv
// Scoreboard bench for sim_tick_ctrl: expected tick and step_done cycles are queued
// when commands are driven and popped as the strobes appear.
module tb_sim_tick_ctrl;
   import sim_tick_pkg::*;

   logic        clk_50Mhz = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic        cmd_err;
   logic        model_busy;
   logic        overrun_clr;
   logic        sim_tick;
   logic        sim_clk;
   logic        step_done;
   logic        overrun;
   logic [1:0]  state;
   logic [31:0] tick_count;

   int unsigned n_run  = 0;
   int unsigned n_fail = 0;
   int unsigned cyc    = 0;
   int unsigned tick_q[$];
   int unsigned done_q[$];
   int unsigned exp_cnt;
   logic        exp_clk;

   sim_tick_ctrl dut (
      .clk_50Mhz   (clk_50Mhz),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_arg     (cmd_arg),
      .cmd_err     (cmd_err),
      .model_busy  (model_busy),
      .overrun_clr (overrun_clr),
      .sim_tick    (sim_tick),
      .sim_clk     (sim_clk),
      .step_done   (step_done),
      .overrun     (overrun),
      .state       (state),
      .tick_count  (tick_count)
   );

   always #10 clk_50Mhz = ~clk_50Mhz;
   always @(posedge clk_50Mhz) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_run++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Must be called while positioned on a falling edge; acc is the accepting edge.
   task automatic send(input op_e op, input logic [15:0] arg, output int unsigned acc);
      acc       = cyc + 1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      @(negedge clk_50Mhz);
      cmd_valid = 1'b0;
      cmd_arg   = '0;
   endtask

   task automatic wait_cyc(input int unsigned target);
      while (cyc < target) @(negedge clk_50Mhz);
   endtask

   always @(negedge clk_50Mhz) begin
      int unsigned exp_t;
      if (sim_tick) begin
         if (tick_q.size() == 0) begin
            check_eq("tick_unexpected", longint'(sim_tick), 0);
         end else begin
            exp_t = tick_q.pop_front();
            check_eq("tick_cycle", cyc, exp_t);
            exp_cnt++;
            exp_clk = ~exp_clk;
            check_eq("tick_count", tick_count, exp_cnt);
            check_eq("sim_clk", sim_clk, exp_clk);
         end
      end
      if (step_done) begin
         if (done_q.size() == 0) begin
            check_eq("done_unexpected", longint'(step_done), 0);
         end else begin
            exp_t = done_q.pop_front();
            check_eq("done_cycle", cyc, exp_t);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run exceeded its time budget at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned a, acc;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
      model_busy = 1'b0; overrun_clr = 1'b0;
      exp_cnt = 0; exp_clk = 1'b0;
      repeat (3) @(negedge clk_50Mhz);
      check_eq("rst_state", state, ST_IDLE);
      check_eq("rst_tick", sim_tick, 0);
      check_eq("rst_clk", sim_clk, 0);
      check_eq("rst_count", tick_count, 0);
      check_eq("rst_overrun", overrun, 0);
      check_eq("rst_ready", cmd_ready, 1);
      rst_n = 1'b1;
      @(negedge clk_50Mhz);

      // Default divisor free run.
      send(OP_RUN, 16'd0, a);
      check_eq("run_state", state, ST_RUN);
      for (int k = 1; k <= 4; k++) tick_q.push_back(a + 250 * k);
      wait_cyc(a + 1000);
      check_eq("run_count_1000", tick_count, 4);
      send(OP_STOP, 16'd0, acc);
      check_eq("stop_state", state, ST_IDLE);

      // SETDIV in IDLE is immediate; STEP 3.
      send(OP_SETDIV, 16'd10, acc);
      send(OP_STEP, 16'd3, a);
      check_eq("step_state", state, ST_STEP);
      for (int k = 1; k <= 3; k++) tick_q.push_back(a + 10 * k);
      done_q.push_back(a + 31);
      wait_cyc(a + 35);
      check_eq("step_end_state", state, ST_IDLE);
      check_eq("step_end_count", tick_count, 7);

      // Busy around one deadline, then long enough to overrun.
      send(OP_RUN, 16'd0, a);
      tick_q.push_back(a + 10); tick_q.push_back(a + 20);
      tick_q.push_back(a + 33); tick_q.push_back(a + 40);
      tick_q.push_back(a + 71);
      wait_cyc(a + 27); model_busy = 1'b1;
      wait_cyc(a + 32); model_busy = 1'b0;
      wait_cyc(a + 45);
      check_eq("busy_short_overrun", overrun, 0);
      model_busy = 1'b1;
      wait_cyc(a + 70); model_busy = 1'b0;
      wait_cyc(a + 72);
      check_eq("busy_long_overrun", overrun, 1);
      overrun_clr = 1'b1;
      wait_cyc(a + 73); overrun_clr = 1'b0;
      check_eq("overrun_cleared", overrun, 0);
      wait_cyc(a + 75);
      send(OP_STOP, 16'd0, acc);

      // Illegal STEP while running; SETDIV 0 clamps to 2 at next wrap.
      send(OP_RUN, 16'd0, a);
      tick_q.push_back(a + 10); tick_q.push_back(a + 12);
      tick_q.push_back(a + 14); tick_q.push_back(a + 16);
      wait_cyc(a + 3);
      send(OP_STEP, 16'd5, acc);
      check_eq("illegal_err", cmd_err, 1);
      check_eq("illegal_state", state, ST_RUN);
      send(OP_SETDIV, 16'd0, acc);
      check_eq("setdiv_no_err", cmd_err, 0);
      wait_cyc(a + 16);
      send(OP_STOP, 16'd0, acc);

      // STOP mid-step: 40 of 100 ticks, no step_done.
      send(OP_STEP, 16'd100, a);
      for (int k = 1; k <= 40; k++) tick_q.push_back(a + 2 * k);
      wait_cyc(a + 80);
      send(OP_STOP, 16'd0, acc);
      wait_cyc(a + 85);
      check_eq("abort_state", state, ST_IDLE);
      check_eq("abort_count", tick_count, 56);

      // STEP 0 completes immediately with no tick.
      done_q.push_back(cyc + 1);
      send(OP_STEP, 16'd0, acc);
      check_eq("step0_state", state, ST_IDLE);
      wait_cyc(acc + 5);
      check_eq("step0_count", tick_count, 56);

      // Reset while running with a tick pending and overrun set.
      model_busy = 1'b1;
      send(OP_RUN, 16'd0, a);
      wait_cyc(a + 5);
      check_eq("pre_rst_overrun", overrun, 1);
      #3 rst_n = 1'b0;
      #1;
      check_eq("async_rst_state", state, ST_IDLE);
      check_eq("async_rst_count", tick_count, 0);
      check_eq("async_rst_overrun", overrun, 0);
      check_eq("async_rst_clk", sim_clk, 0);
      exp_cnt = 0; exp_clk = 1'b0;
      @(negedge clk_50Mhz);
      rst_n = 1'b1; model_busy = 1'b0;
      wait_cyc(cyc + 20);
      check_eq("post_rst_count", tick_count, 0);
      check_eq("post_rst_state", state, ST_IDLE);

      check_eq("tick_q_empty", tick_q.size(), 0);
      check_eq("done_q_empty", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/sim_tick_ctrl.md
# sim_tick_ctrl

Run/stop/single-step controller for the HIL simulation time base. Replaces the free-running 50 MHz divider: it produces a one-cycle `sim_tick` strobe and a toggling `sim_clk` at a programmable rate. Commands start, stop or step the simulation by N ticks. Ticks are withheld while the plant models signal busy, and missed deadlines are flagged.

## Interface
- `DIV_W`, 16: prescaler/divisor width.
- `DIV_RESET`, 250: divisor loaded at reset (50 MHz / 250 = 200 kHz tick rate).
- `DIV_MIN`, 2: smallest legal divisor; smaller SETDIV arguments clamp to this.
- `CNT_W`, 32: `tick_count` width.
- `clk_50Mhz` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 2: 00 STOP, 01 RUN, 10 STEP, 11 SETDIV.
- `cmd_arg` in DIV_W: step count (STEP) or divisor (SETDIV); ignored otherwise.
- `cmd_err` out 1: one-cycle pulse when an accepted command is illegal in the current state.
- `model_busy` in 1: plant models not ready for a tick.
- `overrun_clr` in 1: clears the sticky `overrun` flag.
- `sim_tick` out 1: one-cycle tick strobe.
- `sim_clk` out 1: toggles on every issued tick, giving f = 50 MHz / (2·div).
- `step_done` out 1: one-cycle pulse when a STEP sequence completes.
- `overrun` out 1: sticky flag, set when a tick deadline passes with a tick still pending.
- `state` out 2: 00 IDLE, 01 RUN, 10 STEP.
- `tick_count` out CNT_W: count of issued ticks; wraps modulo 2^CNT_W.

## Operation
- **Reset values:**
  - state = IDLE; divisor = DIV_RESET; prescaler = 0; pending = 0.
  - `sim_tick` = 0, `sim_clk` = 0, `step_done` = 0, `cmd_err` = 0, `overrun` = 0, `tick_count` = 0.
  - `cmd_ready` = 1 (it is 1 in every state).
- **IDLE:**
  - RUN moves to RUN.
  - STEP with N>0 moves to STEP with the remaining count = N.
  - STEP with N=0 stays in IDLE and pulses `step_done` on the next cycle.
  - STOP is a no-op.
  - SETDIV loads the divisor immediately.
- **RUN:**
  - STOP moves to IDLE.
  - RUN and STEP pulse `cmd_err`; the state is unchanged.
  - SETDIV is staged and loaded at the next prescaler wrap.
- **STEP:**
  - Each issued tick decrements the remaining count.
  - The tick that makes the count 0 returns the block to IDLE, with `step_done` high the cycle after that tick.
  - STOP aborts to IDLE with no `step_done`.
  - RUN and STEP pulse `cmd_err`; SETDIV is staged as in RUN.
- **Prescaler:**
  - Counts 0..div−1 in RUN and STEP only.
  - Reaching div−1 makes a tick due.
  - It is cleared on entry to RUN/STEP and on return to IDLE.
- **Busy handshake:**
  - Tick due with `model_busy`=0: the tick is issued.
  - Tick due with `model_busy`=1: pending is set.
  - While pending, a tick is issued on the first cycle with `model_busy`=0, then pending clears.
  - Another tick falling due while pending is still set sets `overrun`; the extra tick is dropped and pending remains.
  - The prescaler never stalls.
- **`overrun`:** `overrun_clr` clears it. If clear and set occur in the same cycle, set wins.
- **STOP while pending:** pending is discarded; `sim_clk` holds its current level.
- **SETDIV argument:** values < DIV_MIN are loaded as DIV_MIN. No `cmd_err` is raised.

## Timing
- All outputs are registered.
- State changes on the edge after the accepting edge.
- With `model_busy`=0, the first `sim_tick` is high in the cycle following the div-th rising edge after the accepting edge. Subsequent ticks are exactly div cycles apart.
- A pending tick is issued the cycle after `model_busy` is seen low.
- `tick_count` and `sim_clk` update in the same cycle `sim_tick` is high.
- `step_done` comes 1 cycle after the final tick; `cmd_err` comes 1 cycle after acceptance.
- Async reset mid-sequence forces all reset values immediately; no `step_done` is produced.

## Structure
- Package `sim_tick_pkg` holds:
  - opcode constants (OP_STOP, OP_RUN, OP_STEP, OP_SETDIV);
  - the state encoding (ST_IDLE, ST_RUN, ST_STEP);
  - DIV_MIN.
- Sub-module `sim_prescaler` contains the counter, the staged-divisor load-on-wrap, the clear input and the `due` strobe.
- The top level holds the FSM, the pending/overrun logic and the counters.

## Test plan
- **Reset, then RUN:** reset, then RUN with the default divisor → `sim_tick` every 250 cycles; `sim_clk` period 500 cycles; `tick_count` = 4 after 1000 cycles.
- **SETDIV then STEP:** SETDIV 10, then STEP 3 → exactly 3 ticks 10 cycles apart; `step_done` 1 cycle after the third tick; state = IDLE; `tick_count` = 3.
- **Busy delay:** RUN at div 10; hold `model_busy` high for 5 cycles around a due tick → that tick issues 1 cycle after busy drops; `overrun` stays 0. Hold busy for 25 cycles → `overrun` = 1; only one tick issued after release; `overrun_clr` returns it to 0.
- **Illegal commands and clamping:** STEP while RUN → `cmd_err` pulse, still RUN. SETDIV 0 → subsequent ticks 2 cycles apart.
- **STOP mid-step:** STOP during STEP 100 after 40 ticks → IDLE, no `step_done`, `tick_count` = 40. STEP 0 from IDLE → `step_done` next cycle, zero ticks.
- **Reset mid-run:** assert `rst_n` low mid-RUN with pending set → all outputs at reset values asynchronously. After release, no tick issues until a RUN command.
